// File: rtl/weight_mem_writer_pkg.sv
// Shared definitions for the weight memory writer: ID field width and the
// load-sequence state encoding.
package weight_mem_writer_pkg;

  // Width of the layer / neuron destination IDs on the shared load bus.
  localparam int unsigned ID_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : weight_mem_writer_pkg

// File: rtl/weight_mem_writer.sv
// Weight memory writer: watches the shared load bus, picks out beats for
// its own (layer, neuron) and writes them to consecutive memory addresses,
// reporting sticky done/error status for the load.
module weight_mem_writer
  import weight_mem_writer_pkg::*;
#(
  parameter int neuronNo     = 0,
  parameter int layerNo      = 2,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16,
  parameter int numWeight    = 784
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ID_W-1:0]         in_layer,
  input  logic [ID_W-1:0]         in_neuron,
  input  logic [dataWidth-1:0]    in_data,
  input  logic                    in_last,
  output logic                    wen,
  output logic [addressWidth:0]   waddr,
  output logic [dataWidth-1:0]    win,
  output logic                    load_done,
  output logic                    load_err
);

  // One extra bit over the address so the counter can sit at numWeight
  // without wrapping when numWeight == 2**(addressWidth+1).
  localparam int unsigned CW = addressWidth + 2;
  localparam logic [CW-1:0] NUM_W    = CW'(numWeight);
  localparam logic [CW-1:0] LAST_IDX = CW'(numWeight - 1);
  localparam logic [ID_W-1:0] MY_LAYER  = ID_W'(layerNo);
  localparam logic [ID_W-1:0] MY_NEURON = ID_W'(neuronNo);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   wen_q, wen_d;
  logic [addressWidth:0]  waddr_q, waddr_d;
  logic [dataWidth-1:0]   win_q, win_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   ready_q;

  logic beat_match;

  // Accepted beat addressed to this writer.
  always_comb begin
    beat_match = in_valid && ready_q &&
                 (in_layer == MY_LAYER) && (in_neuron == MY_NEURON);
  end

  // Next-state logic for the load sequence and the registered write port.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    win_d   = win_q;
    done_d  = done_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (start) begin
          // Restart takes priority: a beat arriving with start is dropped.
          cnt_d  = '0;
          done_d = 1'b0;
          err_d  = 1'b0;
        end else if (beat_match) begin
          if (cnt_q < NUM_W) begin
            wen_d   = 1'b1;
            waddr_d = cnt_q[addressWidth:0];
            win_d   = in_data;
            cnt_d   = cnt_q + CW'(1);
          end else begin
            err_d = 1'b1;
          end
          if (in_last) begin
            if (cnt_q != LAST_IDX) begin
              err_d = 1'b1;
            end
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter, status and write-port registers with async reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      win_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      win_q   <= win_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= 1'b1;
    end
  end

  assign in_ready  = ready_q;
  assign wen       = wen_q;
  assign waddr     = waddr_q;
  assign win       = win_q;
  assign load_done = done_q;
  assign load_err  = err_q;

endmodule : weight_mem_writer

// File: tb/tb_weight_mem_writer.sv
// Directed self-checking bench for weight_mem_writer (numWeight = 4,
// layer 2, neuron 0).
module tb_weight_mem_writer;

  logic        clk;
  logic        rstn;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_layer;
  logic [7:0]  in_neuron;
  logic [15:0] in_data;
  logic        in_last;
  logic        wen;
  logic [10:0] waddr;
  logic [15:0] win;
  logic        load_done;
  logic        load_err;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int base;

  weight_mem_writer #(
    .neuronNo    (0),
    .layerNo     (2),
    .addressWidth(10),
    .dataWidth   (16),
    .numWeight   (4)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_layer (in_layer),
    .in_neuron(in_neuron),
    .in_data  (in_data),
    .in_last  (in_last),
    .wen      (wen),
    .waddr    (waddr),
    .win      (win),
    .load_done(load_done),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count write pulses, sampled mid-cycle.
  always @(negedge clk) if (wen === 1'b1) wr_cnt++;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] lay, input logic [7:0] nrn, input logic [15:0] d,
                      input logic last, input logic exp_w, input logic [10:0] exp_a);
    @(negedge clk);
    in_valid  = 1'b1;
    in_layer  = lay;
    in_neuron = nrn;
    in_data   = d;
    in_last   = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("wen", {31'd0, wen}, {31'd0, exp_w});
    if (exp_w) begin
      chk("waddr", {21'd0, waddr}, {21'd0, exp_a});
      chk("win", {16'd0, win}, {16'd0, d});
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_done_clr", {31'd0, load_done}, 32'd0);
    chk("start_err_clr", {31'd0, load_err}, 32'd0);
  endtask

  task automatic chk_status(input string tag, input logic d, input logic e);
    chk({tag, "_done"}, {31'd0, load_done}, {31'd0, d});
    chk({tag, "_err"}, {31'd0, load_err}, {31'd0, e});
  endtask

  initial begin
    rstn = 1'b1; start = 1'b0; in_valid = 1'b0; in_layer = '0;
    in_neuron = '0; in_data = '0; in_last = 1'b0;

    // Reset values
    #2 rstn = 1'b0;
    #1;
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_wen", {31'd0, wen}, 32'd0);
    chk("rst_waddr", {21'd0, waddr}, 32'd0);
    chk("rst_win", {16'd0, win}, 32'd0);
    chk_status("rst", 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Beat before any start is discarded
    send(8'd2, 8'd0, 16'h0099, 1'b0, 1'b0, 11'd0);

    // Basic load of 4 weights
    pulse_start();
    send(8'd2, 8'd0, 16'h0011, 1'b0, 1'b1, 11'd0);
    send(8'd2, 8'd0, 16'h0022, 1'b0, 1'b1, 11'd1);
    send(8'd2, 8'd0, 16'h0033, 1'b0, 1'b1, 11'd2);
    chk_status("basic_mid", 1'b0, 1'b0);
    send(8'd2, 8'd0, 16'h0044, 1'b1, 1'b1, 11'd3);
    chk_status("basic_end", 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("wen_one_cycle", {31'd0, wen}, 32'd0);
    chk("waddr_hold", {21'd0, waddr}, 32'd3);
    chk("win_hold", {16'd0, win}, 32'h44);

    // Beat after DONE is discarded
    send(8'd2, 8'd0, 16'h0055, 1'b0, 1'b0, 11'd0);
    chk_status("after_done", 1'b1, 1'b0);

    // Interleaved traffic for other neurons / layers
    pulse_start();
    send(8'd2, 8'd0, 16'h00A0, 1'b0, 1'b1, 11'd0);
    send(8'd2, 8'd1, 16'h00B0, 1'b0, 1'b0, 11'd0);
    send(8'd2, 8'd0, 16'h00A1, 1'b0, 1'b1, 11'd1);
    send(8'd3, 8'd0, 16'h00C0, 1'b0, 1'b0, 11'd0);
    send(8'd2, 8'd0, 16'h00A2, 1'b0, 1'b1, 11'd2);
    send(8'd2, 8'd1, 16'h00B1, 1'b1, 1'b0, 11'd0);
    chk_status("ilv_foreign_last", 1'b0, 1'b0);
    send(8'd2, 8'd0, 16'h00A3, 1'b1, 1'b1, 11'd3);
    chk_status("ilv_end", 1'b1, 1'b0);

    // Early last: 3 writes then error
    pulse_start();
    @(negedge clk); base = wr_cnt;
    send(8'd2, 8'd0, 16'h0031, 1'b0, 1'b1, 11'd0);
    send(8'd2, 8'd0, 16'h0032, 1'b0, 1'b1, 11'd1);
    send(8'd2, 8'd0, 16'h0033, 1'b1, 1'b1, 11'd2);
    chk_status("early", 1'b1, 1'b1);
    @(negedge clk); #1;
    chk("early_wr_cnt", wr_cnt - base, 32'd3);

    // Overrun: 6 beats, only 4 written
    pulse_start();
    @(negedge clk); base = wr_cnt;
    send(8'd2, 8'd0, 16'h0051, 1'b0, 1'b1, 11'd0);
    send(8'd2, 8'd0, 16'h0052, 1'b0, 1'b1, 11'd1);
    send(8'd2, 8'd0, 16'h0053, 1'b0, 1'b1, 11'd2);
    send(8'd2, 8'd0, 16'h0054, 1'b0, 1'b1, 11'd3);
    chk_status("over4", 1'b0, 1'b0);
    send(8'd2, 8'd0, 16'h0055, 1'b0, 1'b0, 11'd0);
    chk_status("over5", 1'b0, 1'b1);
    send(8'd2, 8'd0, 16'h0056, 1'b1, 1'b0, 11'd0);
    chk_status("over6", 1'b1, 1'b1);
    chk("over_waddr_hold", {21'd0, waddr}, 32'd3);
    chk("over_win_hold", {16'd0, win}, 32'h54);
    @(negedge clk); #1;
    chk("over_wr_cnt", wr_cnt - base, 32'd4);

    // Restart in LOAD with a coincident beat
    pulse_start();
    send(8'd2, 8'd0, 16'h0061, 1'b0, 1'b1, 11'd0);
    send(8'd2, 8'd0, 16'h0062, 1'b0, 1'b1, 11'd1);
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_layer = 8'd2; in_neuron = 8'd0; in_data = 16'h0063;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    chk("restart_wen", {31'd0, wen}, 32'd0);
    send(8'd2, 8'd0, 16'h0064, 1'b0, 1'b1, 11'd0);

    // Reset mid-load after 2 writes
    pulse_start();
    send(8'd2, 8'd0, 16'h0071, 1'b0, 1'b1, 11'd0);
    send(8'd2, 8'd0, 16'h0072, 1'b0, 1'b1, 11'd1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_wen", {31'd0, wen}, 32'd0);
    chk("mid_rst_waddr", {21'd0, waddr}, 32'd0);
    chk("mid_rst_win", {16'd0, win}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    chk_status("mid_rst", 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    send(8'd2, 8'd0, 16'h0073, 1'b0, 1'b0, 11'd0);
    send(8'd2, 8'd0, 16'h0074, 1'b1, 1'b0, 11'd0);
    chk_status("post_rst_idle", 1'b0, 1'b0);
    pulse_start();
    send(8'd2, 8'd0, 16'h0075, 1'b0, 1'b1, 11'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_weight_mem_writer
